// File: rtl/uart_sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo_pkg
// Shared definitions for the UART synchronous FIFO slice.
//   clogb2            : ceiling log2, used to size pointers from DEPTH
//   FWFT_STANDARD     : read data appears one cycle after an accepted read
//   FWFT_FALLTHROUGH  : head word is visible on the output without a read
// -----------------------------------------------------------------------------
package uart_sync_fifo_pkg;

    localparam int FWFT_STANDARD    = 0;
    localparam int FWFT_FALLTHROUGH = 1;

    // Number of address bits needed to index 'value' entries.
    function automatic int clogb2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// -----------------------------------------------------------------------------
// uart_fifo_ram
// Simple dual-port storage for the UART FIFO: one write port, one read port.
// In standard mode the read port is registered (data follows re_i by one
// cycle and holds otherwise); in fall-through mode the read is combinational
// so the word at raddr_i is always visible.
// Ports:
//   clk      : clock
//   rst_n    : async active-low reset, clears only the read register
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable (standard mode only)
//   raddr_i  : read address
//   rdata_o  : read data
// -----------------------------------------------------------------------------
module uart_fifo_ram
    import uart_sync_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = FWFT_STANDARD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array; deliberately has no reset so it maps onto RAM cells.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    generate
        if (FWFT == FWFT_FALLTHROUGH) begin : gFallThrough
            // The head word is exposed directly; the read strobe and the
            // read-register reset have no role in this mode.
            logic unusedReadRegInputs;
            assign unusedReadRegInputs = ^{rst_n, re_i};
            assign rdata_o = mem[raddr_i];
        end else begin : gRegistered
            logic [WIDTH-1:0] rdata_q;

            // Registered read: a write to the same address on the same edge
            // returns the old word, which is the one being consumed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (re_i) begin
                    rdata_q <= mem[raddr_i];
                end
            end

            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Parametrised single-clock FIFO shared by the UART TX and RX paths.
// Supports standard and first-word-fall-through reads, an exact fill count
// (0..DEPTH), write+read on a full FIFO, synchronous flush, and one-cycle
// overflow/underflow pulses.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : async active-low reset
//   clr        : synchronous flush, wins over wr_en/rd_en
//   din        : write data
//   wr_en      : write request
//   rd_en      : read request (standard: fetch, FWFT: pop the word on dout)
//   dout       : read data
//   valid      : standard: one-cycle pulse with new dout; FWFT: !empty
//   full/empty : occupancy flags
//   prog_full  : count >= PROG_FULL
//   prog_empty : count <= PROG_EMPTY
//   overflow   : pulse after a rejected write
//   underflow  : pulse after a rejected read
//   fifo_cnt   : stored word count
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_sync_fifo_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 16,
    parameter  int FWFT       = FWFT_STANDARD,
    parameter  int PROG_EMPTY = 4,
    parameter  int PROG_FULL  = 12,
    localparam int ADDR_WIDTH = clogb2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_cnt
);

    localparam logic [ADDR_WIDTH:0] CNT_DEPTH      = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_PROG_EMPTY = (ADDR_WIDTH+1)'(PROG_EMPTY);
    localparam logic [ADDR_WIDTH:0] CNT_PROG_FULL  = (ADDR_WIDTH+1)'(PROG_FULL);

    logic                  rdOk;
    logic                  wrOk;
    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  progEmpty_q, progEmpty_d;
    logic                  progFull_q, progFull_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [WIDTH-1:0]      ramRdata;

    // Acceptance: a full FIFO still takes a write when a read frees a slot
    // on the same edge, so sustained write+read keeps the count constant.
    assign rdOk = rd_en && !empty_q && !clr;
    assign wrOk = wr_en && !clr && (!full_q || rdOk);

    // Next-state for pointers, count and flags. Flags are derived from the
    // next count so they are registered alongside it and never lag a cycle.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        cnt_d   = cnt_q;
        if (clr) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            cnt_d   = '0;
        end else begin
            if (wrOk) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (rdOk) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, wrOk} - {{ADDR_WIDTH{1'b0}}, rdOk};
        end
        empty_d     = (cnt_d == '0);
        full_d      = (cnt_d == CNT_DEPTH);
        progEmpty_d = (cnt_d <= CNT_PROG_EMPTY);
        progFull_d  = (cnt_d >= CNT_PROG_FULL);
        overflow_d  = wr_en && !wrOk && !clr;
        underflow_d = rd_en && !rdOk && !clr;
    end

    // State registers; reset values match an empty FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            cnt_q       <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            progEmpty_q <= 1'b1;
            progFull_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            cnt_q       <= cnt_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            progEmpty_q <= progEmpty_d;
            progFull_q  <= progFull_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    uart_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FWFT       (FWFT)
    ) uRam (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wrOk),
        .waddr_i (wrPtr_q),
        .wdata_i (din),
        .re_i    (rdOk),
        .raddr_i (rdPtr_q),
        .rdata_o (ramRdata)
    );

    generate
        if (FWFT == FWFT_FALLTHROUGH) begin : gFwftOut
            // Stale storage contents must not leak out while empty.
            assign dout  = empty_q ? '0 : ramRdata;
            assign valid = !empty_q;
        end else begin : gStdOut
            logic valid_q;

            // valid marks the cycle in which the registered read data is new.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rdOk;
                end
            end

            assign dout  = ramRdata;
            assign valid = valid_q;
        end
    endgenerate

    assign full       = full_q;
    assign empty      = empty_q;
    assign prog_full  = progFull_q;
    assign prog_empty = progEmpty_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_sync_fifo
// Drives a standard-mode and a fall-through-mode FIFO with identical inputs
// and compares both against a queue-based reference model, plus a table of
// hand-computed vectors for the standard instance.
// -----------------------------------------------------------------------------
module tb_uart_sync_fifo;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 16;
    localparam int PROG_EMPTY = 4;
    localparam int PROG_FULL  = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic             wrEn;
    logic             rdEn;

    logic [WIDTH-1:0] stdDout, fwDout;
    logic             stdValid, fwValid;
    logic             stdFull, fwFull;
    logic             stdEmpty, fwEmpty;
    logic             stdProgFull, fwProgFull;
    logic             stdProgEmpty, fwProgEmpty;
    logic             stdOverflow, fwOverflow;
    logic             stdUnderflow, fwUnderflow;
    logic [4:0]       stdCnt, fwCnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: the FIFO contents as a plain queue.
    logic [WIDTH-1:0] modelQ[$];
    logic [WIDTH-1:0] expStdDout;
    logic             expStdValid;
    logic             expOverflow;
    logic             expUnderflow;

    typedef struct {
        logic       clr;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         expCnt;
        logic       expEmpty;
        logic       expFull;
        logic       expOverflow;
        logic       expUnderflow;
        logic       expValid;
        logic [7:0] expDout;
    } vector_t;

    vector_t vectors[10];

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    uart_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0),
        .PROG_EMPTY(PROG_EMPTY), .PROG_FULL(PROG_FULL)
    ) dutStd (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr_en(wrEn), .rd_en(rdEn),
        .dout(stdDout), .valid(stdValid), .full(stdFull), .empty(stdEmpty),
        .prog_full(stdProgFull), .prog_empty(stdProgEmpty),
        .overflow(stdOverflow), .underflow(stdUnderflow), .fifo_cnt(stdCnt)
    );

    uart_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1),
        .PROG_EMPTY(PROG_EMPTY), .PROG_FULL(PROG_FULL)
    ) dutFw (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr_en(wrEn), .rd_en(rdEn),
        .dout(fwDout), .valid(fwValid), .full(fwFull), .empty(fwEmpty),
        .prog_full(fwProgFull), .prog_empty(fwProgEmpty),
        .overflow(fwOverflow), .underflow(fwUnderflow), .fifo_cnt(fwCnt)
    );

    task automatic compare(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        expStdDout   = '0;
        expStdValid  = 1'b0;
        expOverflow  = 1'b0;
        expUnderflow = 1'b0;
    endtask

    // One clock edge of FIFO behaviour, from the acceptance rules only.
    task automatic modelStep(input logic c, input logic w, input logic r, input logic [7:0] d);
        bit rdOk;
        bit wrOk;
        rdOk = r && (modelQ.size() > 0) && !c;
        wrOk = w && !c && ((modelQ.size() < DEPTH) || rdOk);
        expOverflow  = w && !wrOk && !c;
        expUnderflow = r && !rdOk && !c;
        expStdValid  = rdOk;
        if (c) begin
            modelQ.delete();
        end else begin
            if (rdOk) expStdDout = modelQ.pop_front();
            if (wrOk) modelQ.push_back(d);
        end
    endtask

    task automatic checkOutput(input string tag);
        int n;
        logic [7:0] head;
        n = modelQ.size();
        head = (n > 0) ? modelQ[0] : 8'h00;
        compare({tag, " std cnt"}, stdCnt, n);
        compare({tag, " fw cnt"}, fwCnt, n);
        compare({tag, " std empty"}, stdEmpty, n == 0);
        compare({tag, " fw empty"}, fwEmpty, n == 0);
        compare({tag, " std full"}, stdFull, n == DEPTH);
        compare({tag, " fw full"}, fwFull, n == DEPTH);
        compare({tag, " std progEmpty"}, stdProgEmpty, n <= PROG_EMPTY);
        compare({tag, " fw progEmpty"}, fwProgEmpty, n <= PROG_EMPTY);
        compare({tag, " std progFull"}, stdProgFull, n >= PROG_FULL);
        compare({tag, " fw progFull"}, fwProgFull, n >= PROG_FULL);
        compare({tag, " std overflow"}, stdOverflow, expOverflow);
        compare({tag, " fw overflow"}, fwOverflow, expOverflow);
        compare({tag, " std underflow"}, stdUnderflow, expUnderflow);
        compare({tag, " fw underflow"}, fwUnderflow, expUnderflow);
        compare({tag, " std valid"}, stdValid, expStdValid);
        compare({tag, " std dout"}, stdDout, expStdDout);
        compare({tag, " fw valid"}, fwValid, n > 0);
        compare({tag, " fw dout"}, fwDout, head);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, sample 1 unit later.
    task automatic applyStimulus(input logic c, input logic w, input logic r, input logic [7:0] d, input string tag);
        clr  = c;
        wrEn = w;
        rdEn = r;
        din  = d;
        @(posedge clk);
        modelStep(c, w, r, d);
        #1;
        checkOutput(tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic asyncResetPulse(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        clr  = 1'b0;
        wrEn = 1'b0;
        rdEn = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Main test sequence.
    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wrEn  = 1'b0;
        rdEn  = 1'b0;
        din   = '0;
        modelReset();

        vectors[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vectors[1] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vectors[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
        vectors[3] = '{1'b0, 1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
        vectors[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
        vectors[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        vectors[6] = '{1'b0, 1'b1, 1'b1, 8'h3C, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        vectors[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        vectors[8] = '{1'b1, 1'b1, 1'b0, 8'h77, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
        vectors[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};

        #22;
        checkOutput("reset");
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].clr, vectors[i].wr, vectors[i].rd, vectors[i].din, $sformatf("vec%0d", i));
            compare($sformatf("vec%0d table cnt", i), stdCnt, vectors[i].expCnt);
            compare($sformatf("vec%0d table empty", i), stdEmpty, vectors[i].expEmpty);
            compare($sformatf("vec%0d table full", i), stdFull, vectors[i].expFull);
            compare($sformatf("vec%0d table overflow", i), stdOverflow, vectors[i].expOverflow);
            compare($sformatf("vec%0d table underflow", i), stdUnderflow, vectors[i].expUnderflow);
            compare($sformatf("vec%0d table valid", i), stdValid, vectors[i].expValid);
            compare($sformatf("vec%0d table dout", i), stdDout, vectors[i].expDout);
        end

        // Fill to full, then one rejected write.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(i), "fill");
        compare("fill full flag", stdFull, 1);
        compare("fill count", stdCnt, DEPTH);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hEE, "overflowWrite");
        compare("overflow pulse", stdOverflow, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "overflowIdle");
        compare("overflow one cycle", stdOverflow, 0);

        // Drain in order, then one rejected read.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "drain");
        compare("drain last dout", stdDout, 8'h0F);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "underflowRead");
        compare("underflow pulse", stdUnderflow, 1);

        // Fall-through visibility of a single word.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5, "fwftWrite");
        compare("fwft shows A5", fwDout, 8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "fwftPop");
        compare("fwft dout zero when empty", fwDout, 8'h00);

        // Full FIFO with simultaneous write+read across two pointer wraps.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), "refill");
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'h80 + i), "fullThroughput");
        compare("throughput count holds", stdCnt, DEPTH);

        // Flush has priority over a write.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "preClear");
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h50 + i), "fillNine");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, "clrWithWrite");
        compare("clr count", stdCnt, 0);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, (i > 2), 8'(8'h60 + i), "burst");
        wrEn = 1'b1;
        asyncResetPulse("asyncReset");

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            logic c, w, r;
            int wrBias;
            wrBias = (i % 300 < 150) ? 70 : 30;
            c = ($urandom_range(0, 99) < 2);
            w = ($urandom_range(0, 99) < wrBias);
            r = ($urandom_range(0, 99) < 50);
            applyStimulus(c, w, r, 8'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
